// File: rtl/axis_splitter_fanout.sv
// Splits one wide AXI-Stream beat into N_LANES independent lanes, each behind its own FWFT FIFO.
// Optional AXIS_SPLIT_STATS_EN adds a saturating input-stall counter (stall_cnt).
module axis_splitter_fanout #(
    parameter int unsigned LANE_W  = 64,
    parameter int unsigned N_LANES = 2,
    parameter int unsigned DEPTH   = 4,
    localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [N_LANES-1:0]          lane_en,
    input  logic [N_LANES*LANE_W-1:0]   s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    output logic [N_LANES*LANE_W-1:0]   m_axis_tdata,
    output logic [N_LANES-1:0]          m_axis_tvalid,
    input  logic [N_LANES-1:0]          m_axis_tready,
    output logic [N_LANES-1:0]          m_axis_tlast,
`ifdef AXIS_SPLIT_STATS_EN
    output logic [31:0]                 stall_cnt,
`endif
    output logic [N_LANES*CW-1:0]       lane_level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] LevelFull = CW'(DEPTH);

    logic [N_LANES-1:0][PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [N_LANES-1:0][PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [N_LANES-1:0][CW-1:0] level_q, level_d;
    logic [N_LANES-1:0]         push, pop;
    logic                       accept;
    logic [LANE_W:0]            head;

    // Each entry holds {tlast, data}; contents survive reset on purpose.
    logic [LANE_W:0] mem_q [N_LANES][DEPTH];

    // Ready looks only at registered levels, never at downstream ready.
    always_comb begin
        s_axis_tready = !areset;
        for (int k = 0; k < int'(N_LANES); k++) begin
            if (lane_en[k] && (level_q[k] == LevelFull)) begin
                s_axis_tready = 1'b0;
            end
        end
    end

    always_comb begin
        accept = s_axis_tvalid && s_axis_tready;
        for (int k = 0; k < int'(N_LANES); k++) begin
            push[k]     = accept && lane_en[k];
            pop[k]      = m_axis_tvalid[k] && m_axis_tready[k];
            wr_ptr_d[k] = push[k] ? wr_ptr_q[k] + PW'(1) : wr_ptr_q[k];
            rd_ptr_d[k] = pop[k] ? rd_ptr_q[k] + PW'(1) : rd_ptr_q[k];
            level_d[k]  = level_q[k];
            if (push[k] && !pop[k]) begin
                level_d[k] = level_q[k] + CW'(1);
            end else if (!push[k] && pop[k]) begin
                level_d[k] = level_q[k] - CW'(1);
            end
            if (areset) begin
                wr_ptr_d[k] = '0;
                rd_ptr_d[k] = '0;
                level_d[k]  = '0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        level_q  <= level_d;
    end

    always_ff @(posedge aclk) begin
        for (int k = 0; k < int'(N_LANES); k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k]] <= {s_axis_tlast, s_axis_tdata[k*LANE_W +: LANE_W]};
            end
        end
    end

    // Head is gated by valid so stale memory never leaks out after reset.
    always_comb begin
        head = '0;
        for (int k = 0; k < int'(N_LANES); k++) begin
            head                             = mem_q[k][rd_ptr_q[k]];
            m_axis_tvalid[k]                 = (level_q[k] != '0);
            m_axis_tdata[k*LANE_W +: LANE_W] = m_axis_tvalid[k] ? head[LANE_W-1:0] : '0;
            m_axis_tlast[k]                  = m_axis_tvalid[k] && head[LANE_W];
            lane_level[k*CW +: CW]           = level_q[k];
        end
    end

`ifdef AXIS_SPLIT_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (areset) begin
            stall_cnt_d = '0;
        end else if (s_axis_tvalid && !s_axis_tready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge aclk) begin
        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_axis_splitter_fanout.sv
// Directed self-checking bench for axis_splitter_fanout (LANE_W=64, N_LANES=2, DEPTH=4).
// Define AXIS_SPLIT_STATS_EN to also exercise the stall counter.
module tb_axis_splitter_fanout;

    logic         aclk = 1'b0;
    logic         areset;
    logic [1:0]   lane_en;
    logic [127:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [127:0] m_axis_tdata;
    logic [1:0]   m_axis_tvalid;
    logic [1:0]   m_axis_tready;
    logic [1:0]   m_axis_tlast;
    logic [5:0]   lane_level;
`ifdef AXIS_SPLIT_STATS_EN
    logic [31:0]  stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axis_splitter_fanout #(.LANE_W(64), .N_LANES(2), .DEPTH(4)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .lane_en       (lane_en),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
`ifdef AXIS_SPLIT_STATS_EN
        .stall_cnt     (stall_cnt),
`endif
        .lane_level    (lane_level)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1; s_axis_tvalid = 1'b1; lane_en = 2'b11; m_axis_tready = 2'b11;
        s_axis_tdata = {64'hDEAD, 64'hBEEF}; s_axis_tlast = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (s_axis_tready !== 1'b0) begin
                errors++; $display("FAIL reset_tready cyc%0d: got %b want 0", i, s_axis_tready);
            end
            checks++;
            if (m_axis_tvalid !== 2'b00 || lane_level !== 6'd0 || m_axis_tdata !== 128'd0) begin
                errors++;
                $display("FAIL reset_out cyc%0d: valid %b level %h data %h want 0", i,
                         m_axis_tvalid, lane_level, m_axis_tdata);
            end
        end
        areset = 1'b0; s_axis_tvalid = 1'b0;
        #1;
        checks++;
        if (lane_level !== 6'd0 || s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL reset_release: level %h ready %b want 0/1",
                               lane_level, s_axis_tready);
        end
    endtask

    task automatic test_passthrough();
        m_axis_tready = 2'b11; lane_en = 2'b11;
        s_axis_tdata = {64'h2, 64'h1}; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 2'b11 || m_axis_tdata !== {64'h2, 64'h1}) begin
            errors++; $display("FAIL pass_data: valid %b data %h want 11 / 2,1",
                               m_axis_tvalid, m_axis_tdata);
        end
        checks++;
        if (m_axis_tlast !== 2'b11 || lane_level !== 6'b001_001) begin
            errors++; $display("FAIL pass_last_level: last %b level %b want 11 / 001001",
                               m_axis_tlast, lane_level);
        end
        tick();
        checks++;
        if (m_axis_tvalid !== 2'b00 || lane_level !== 6'd0) begin
            errors++; $display("FAIL pass_drain: valid %b level %b want 0",
                               m_axis_tvalid, lane_level);
        end
    endtask

    task automatic test_independent_drain();
        int idx = 4;
        int rx0 = 4;
        int rx1 = 0;
        logic acc;
        m_axis_tready = 2'b01; lane_en = 2'b11;
        for (int i = 0; i < 4; i++) begin
            s_axis_tdata = {64'(32'h20 + i), 64'(32'h10 + i)}; s_axis_tvalid = 1'b1;
            #1;
            checks++;
            if (s_axis_tready !== 1'b1) begin
                errors++; $display("FAIL drain_accept%0d: ready %b want 1", i, s_axis_tready);
            end
            tick();
            checks++;
            if (m_axis_tvalid[0] !== 1'b1 || m_axis_tdata[63:0] !== 64'(32'h10 + i)) begin
                errors++; $display("FAIL drain_lane0_%0d: got %b/%h want 1/%h", i,
                                   m_axis_tvalid[0], m_axis_tdata[63:0], 32'h10 + i);
            end
        end
        s_axis_tdata = {64'h24, 64'h14};
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (s_axis_tready !== 1'b0 || lane_level[5:3] !== 3'd4) begin
                errors++; $display("FAIL drain_stall%0d: ready %b lvl1 %0d want 0/4", i,
                                   s_axis_tready, lane_level[5:3]);
            end
            tick();
        end
        checks++;
        if (lane_level[2:0] !== 3'd0) begin
            errors++; $display("FAIL drain_lane0_empty: lvl0 %0d want 0", lane_level[2:0]);
        end
        m_axis_tready = 2'b11;
        for (int c = 0; c < 30; c++) begin
            if (rx1 >= 6 && rx0 >= 6 && idx >= 6) break;
            s_axis_tvalid = (idx < 6);
            s_axis_tdata  = {64'(32'h20 + idx), 64'(32'h10 + idx)};
            #1;
            if (m_axis_tvalid[1]) begin
                checks++;
                if (m_axis_tdata[127:64] !== 64'(32'h20 + rx1)) begin
                    errors++; $display("FAIL drain_order1: got %h want %h",
                                       m_axis_tdata[127:64], 32'h20 + rx1);
                end
                rx1++;
            end
            if (m_axis_tvalid[0]) begin
                checks++;
                if (m_axis_tdata[63:0] !== 64'(32'h10 + rx0)) begin
                    errors++; $display("FAIL drain_order0: got %h want %h",
                                       m_axis_tdata[63:0], 32'h10 + rx0);
                end
                rx0++;
            end
            acc = s_axis_tvalid && s_axis_tready;
            tick();
            if (acc) idx++;
        end
        s_axis_tvalid = 1'b0;
        checks++;
        if (rx0 != 6 || rx1 != 6 || idx != 6) begin
            errors++; $display("FAIL drain_count: rx0 %0d rx1 %0d sent %0d want 6/6/6",
                               rx0, rx1, idx);
        end
    endtask

    task automatic test_full_pop();
        m_axis_tready = 2'b00; lane_en = 2'b01; s_axis_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_axis_tdata = {64'h0, 64'(32'hA0 + i)};
            tick();
        end
        s_axis_tdata = {64'h0, 64'hA4}; m_axis_tready = 2'b01;
        #1;
        checks++;
        if (s_axis_tready !== 1'b0 || lane_level[2:0] !== 3'd4) begin
            errors++; $display("FAIL full_pop_block: ready %b lvl0 %0d want 0/4",
                               s_axis_tready, lane_level[2:0]);
        end
        tick();
        m_axis_tready = 2'b00;
        #1;
        checks++;
        if (s_axis_tready !== 1'b1 || lane_level[2:0] !== 3'd3) begin
            errors++; $display("FAIL full_pop_next: ready %b lvl0 %0d want 1/3",
                               s_axis_tready, lane_level[2:0]);
        end
        tick();
        s_axis_tvalid = 1'b0;
        checks++;
        if (lane_level[2:0] !== 3'd4) begin
            errors++; $display("FAIL full_pop_level: lvl0 %0d want 4", lane_level[2:0]);
        end
        m_axis_tready = 2'b01;
        for (int i = 1; i < 5; i++) begin
            #1;
            checks++;
            if (m_axis_tdata[63:0] !== 64'(32'hA0 + i)) begin
                errors++; $display("FAIL full_pop_order: got %h want %h",
                                   m_axis_tdata[63:0], 32'hA0 + i);
            end
            tick();
        end
        checks++;
        if (lane_level !== 6'd0) begin
            errors++; $display("FAIL full_pop_empty: level %b want 0", lane_level);
        end
    endtask

    task automatic test_masking();
        m_axis_tready = 2'b00; lane_en = 2'b10; s_axis_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_axis_tdata = {64'(32'hB0 + i), 64'h0};
            tick();
        end
        lane_en = 2'b01; m_axis_tready = 2'b01; s_axis_tdata = {64'hFF, 64'hC0};
        #1;
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL mask_ready: got %b want 1", s_axis_tready);
        end
        tick();
        lane_en = 2'b00;
        #1;
        checks++;
        if (m_axis_tvalid[0] !== 1'b1 || m_axis_tdata[63:0] !== 64'hC0) begin
            errors++; $display("FAIL mask_lane0: got %b/%h want 1/c0",
                               m_axis_tvalid[0], m_axis_tdata[63:0]);
        end
        checks++;
        if (lane_level[5:3] !== 3'd4 || m_axis_tdata[127:64] !== 64'hB0) begin
            errors++; $display("FAIL mask_lane1: lvl %0d head %h want 4/b0",
                               lane_level[5:3], m_axis_tdata[127:64]);
        end
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL mask_drop_ready: got %b want 1", s_axis_tready);
        end
        tick();
        s_axis_tvalid = 1'b0;
        checks++;
        if (lane_level !== 6'b100_000) begin
            errors++; $display("FAIL mask_drop_level: got %b want 100000", lane_level);
        end
        lane_en = 2'b11; m_axis_tready = 2'b11;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (lane_level !== 6'd0) begin
            errors++; $display("FAIL mask_cleanup: level %b want 0", lane_level);
        end
    endtask

    task automatic test_reset_mid();
        m_axis_tready = 2'b00; lane_en = 2'b11; s_axis_tvalid = 1'b1;
        s_axis_tdata = {64'h77, 64'h66};
        tick(); tick();
        areset = 1'b1;
        tick();
        checks++;
        if (lane_level !== 6'd0 || m_axis_tvalid !== 2'b00) begin
            errors++; $display("FAIL mid_reset: level %b valid %b want 0", lane_level,
                               m_axis_tvalid);
        end
        areset = 1'b0; s_axis_tdata = {64'h99, 64'h88}; s_axis_tlast = 1'b1;
        tick();
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        #1;
        checks++;
        if (m_axis_tdata !== {64'h99, 64'h88} || m_axis_tlast !== 2'b11 ||
            lane_level !== 6'b001_001) begin
            errors++; $display("FAIL mid_after: data %h last %b level %b want 99,88/11/001001",
                               m_axis_tdata, m_axis_tlast, lane_level);
        end
        m_axis_tready = 2'b11;
        tick();
    endtask

`ifdef AXIS_SPLIT_STATS_EN
    task automatic test_stats();
        areset = 1'b1;
        tick();
        areset = 1'b0; m_axis_tready = 2'b00; lane_en = 2'b01; s_axis_tvalid = 1'b1;
        s_axis_tdata = {64'h0, 64'h5};
        for (int i = 0; i < 14; i++) tick();
        s_axis_tvalid = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 32'd10) begin
            errors++; $display("FAIL stats_count: got %0d want 10", stall_cnt);
        end
        areset = 1'b1;
        tick();
        areset = 1'b0;
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++; $display("FAIL stats_clear: got %0d want 0", stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_passthrough();
        test_independent_drain();
        test_full_pop();
        test_masking();
        test_reset_mid();
`ifdef AXIS_SPLIT_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
